// File: rtl/ds_pkg.sv
// Shared constants for the downsampling processor stages.
// Default frame geometry, receive FSM encoding and frame size helper.
// No logic; imported by the receive, process and transmit stages.
package ds_pkg;

   localparam int DEF_IMG_W      = 256;
   localparam int DEF_IMG_H      = 256;
   localparam int DEF_START_ROWS = 2;

   localparam int FRAME_BYTES = DEF_IMG_W * DEF_IMG_H;

   // Receive FSM encoding, kept as plain constants for legacy tools.
   localparam logic [1:0] RX_IDLE = 2'b00;
   localparam logic [1:0] RX_RECV = 2'b01;
   localparam logic [1:0] RX_DONE = 2'b10;

   function automatic int frame_bytes(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/rc_counter.sv
// Row/column position counter for a W x H raster, row-major order.
// Latency: position advances on the edge where en_i is high; outputs are the current position.
// No backpressure; the caller decides when to advance. Wraps to (0,0) after the last pixel.
module rc_counter #(
   parameter int W = 4,
   parameter int H = 4
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 en_i,
   output logic [$clog2(H)-1:0] row_o,
   output logic [$clog2(W)-1:0] col_o,
   output logic                 last_o
);

   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_wrap;

   assign col_wrap = (col_q == CW'(W - 1));
   assign last_o   = col_wrap && (row_q == RW'(H - 1));
   assign row_o    = row_q;
   assign col_o    = col_q;

   // Next position: column steps each enable, row steps on column wrap.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (en_i) begin
         if (col_wrap) begin
            col_d = '0;
            row_d = last_o ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Position registers.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/rx_frame_writer.sv
// Writes received bytes into frame RAM in row-major order and flags progress.
// Latency: 1 clock from accepted rx_valid to mem_we; all outputs registered.
// No stall: one byte per cycle accepted; bytes after frame completion are dropped and flagged.
module rx_frame_writer
   import ds_pkg::*;
#(
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int START_ROWS = DEF_START_ROWS,
   parameter int ADDR_W     = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [7:0]               mem_wdata,
   output logic [$clog2(IMG_H)-1:0] row,
   output logic [$clog2(IMG_W)-1:0] col,
   output logic                     begin_process,
   output logic                     end_receive,
   output logic                     overflow
);

   localparam int RW    = $clog2(IMG_H);
   localparam int CW    = $clog2(IMG_W);
   localparam int FRAME = frame_bytes(IMG_W, IMG_H);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME - 1);
   localparam logic [ADDR_W-1:0] BEGIN_ADDR = ADDR_W'(START_ROWS * IMG_W - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic              bp_q, bp_d;
   logic              er_q, er_d;
   logic              ov_q, ov_d;

   logic [RW-1:0]     rc_row;
   logic [CW-1:0]     rc_col;
   logic              rc_last;
   logic              accept;
   logic              last_byte;

   // A byte is taken only while enabled and before the frame is complete.
   assign accept = en && rx_valid && (state_q != RX_DONE);

   // Completion is an address compare against the constant frame end; the
   // raster counter reaches its last pixel on the same byte by construction.
   assign last_byte = (addr_q == LAST_ADDR) && rc_last;

   rc_counter #(
      .W (IMG_W),
      .H (IMG_H)
   ) u_rc (
      .clock_i (clock),
      .reset_i (reset),
      .en_i    (accept),
      .row_o   (rc_row),
      .col_o   (rc_col),
      .last_o  (rc_last)
   );

   // Next-state: write pipeline, address counter, sticky flags and FSM.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = accept;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      row_d   = row_q;
      col_d   = col_q;
      bp_d    = bp_q;
      er_d    = er_q;
      ov_d    = ov_q;

      if (accept) begin
         maddr_d = addr_q;
         wdata_d = rx_data;
         row_d   = rc_row;
         col_d   = rc_col;
         // Hold at the last address rather than rolling over.
         if (!last_byte) begin
            addr_d = addr_q + ADDR_W'(1);
         end
         if (addr_q == BEGIN_ADDR) begin
            bp_d = 1'b1;
         end
         if (last_byte) begin
            er_d = 1'b1;
         end
      end

      case (state_q)
         RX_IDLE: begin
            if (accept) begin
               state_d = last_byte ? RX_DONE : RX_RECV;
            end
         end
         RX_RECV: begin
            if (accept && last_byte) begin
               state_d = RX_DONE;
            end
         end
         RX_DONE: begin
            // Late bytes are discarded whatever the enable says.
            if (rx_valid) begin
               ov_d = 1'b1;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   // State and output registers; reset leaves RAM contents untouched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RX_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
         row_q   <= '0;
         col_q   <= '0;
         bp_q    <= 1'b0;
         er_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         row_q   <= row_d;
         col_q   <= col_d;
         bp_q    <= bp_d;
         er_q    <= er_d;
         ov_q    <= ov_d;
      end
   end

   assign mem_we        = we_q;
   assign mem_addr      = maddr_q;
   assign mem_wdata     = wdata_q;
   assign row           = row_q;
   assign col           = col_q;
   assign begin_process = bp_q;
   assign end_receive   = er_q;
   assign overflow      = ov_q;

endmodule

// File: tb/tb_rx_frame_writer.sv
// Directed bench for rx_frame_writer on a 4x4 frame.
// Two instances share stimulus: START_ROWS=2 and START_ROWS=IMG_H.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rx_frame_writer;

   logic       clock = 1'b0;
   logic       reset;
   logic       en;
   logic       rx_valid;
   logic [7:0] rx_data;

   logic       we2, bp2, er2, ov2;
   logic [3:0] addr2;
   logic [7:0] wdata2;
   logic [1:0] row2, col2;

   logic       we4, bp4, er4, ov4;
   logic [3:0] addr4;
   logic [7:0] wdata4;
   logic [1:0] row4, col4;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   rx_frame_writer #(.IMG_W(4), .IMG_H(4), .START_ROWS(2), .ADDR_W(4)) u_dut (
      .clock(clock), .reset(reset), .en(en), .rx_valid(rx_valid), .rx_data(rx_data),
      .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .row(row2), .col(col2),
      .begin_process(bp2), .end_receive(er2), .overflow(ov2)
   );

   rx_frame_writer #(.IMG_W(4), .IMG_H(4), .START_ROWS(4), .ADDR_W(4)) u_dut4 (
      .clock(clock), .reset(reset), .en(en), .rx_valid(rx_valid), .rx_data(rx_data),
      .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4), .row(row4), .col(col4),
      .begin_process(bp4), .end_receive(er4), .overflow(ov4)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic [3:0] addr;
      logic [1:0] row;
      logic [1:0] col;
      logic       bp;
      logic       er;
      logic       bp4;
   } vec_t;

   vec_t tbl[16];

   initial begin
      // Normal frame, hand-computed row-major positions and flag timing.
      tbl[0]  = '{8'h10, 4'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{8'h11, 4'd1,  2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{8'h12, 4'd2,  2'd0, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{8'h13, 4'd3,  2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{8'h14, 4'd4,  2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{8'h15, 4'd5,  2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{8'h16, 4'd6,  2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{8'h17, 4'd7,  2'd1, 2'd3, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{8'h18, 4'd8,  2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{8'h19, 4'd9,  2'd2, 2'd1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{8'h1A, 4'd10, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{8'h1B, 4'd11, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{8'h1C, 4'd12, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{8'h1D, 4'd13, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{8'h1E, 4'd14, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{8'h1F, 4'd15, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1};

      en = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_we", we2, 0);
      chk("rst_addr", addr2, 0);
      chk("rst_wdata", wdata2, 0);
      chk("rst_rowcol", {row2, col2}, 0);
      chk("rst_flags", {bp2, er2, ov2}, 0);
      chk("rst_flags4", {we4, bp4, er4, ov4}, 0);
      reset = 1'b0;
      @(negedge clock);

      // Normal frame, one byte every 3 cycles; second instance checks START_ROWS=IMG_H.
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1;
         rx_data  = tbl[i].data;
         @(negedge clock);
         rx_valid = 1'b0;
         chk($sformatf("s1_we[%0d]", i), we2, 1);
         chk($sformatf("s1_addr[%0d]", i), addr2, tbl[i].addr);
         chk($sformatf("s1_wdata[%0d]", i), wdata2, tbl[i].data);
         chk($sformatf("s1_row[%0d]", i), row2, tbl[i].row);
         chk($sformatf("s1_col[%0d]", i), col2, tbl[i].col);
         chk($sformatf("s1_bp[%0d]", i), bp2, tbl[i].bp);
         chk($sformatf("s1_er[%0d]", i), er2, tbl[i].er);
         chk($sformatf("s6_bp[%0d]", i), bp4, tbl[i].bp4);
         chk($sformatf("s6_er[%0d]", i), er4, tbl[i].er);
         repeat (2) begin
            @(negedge clock);
            chk($sformatf("s1_gap_we[%0d]", i), we2, 0);
         end
      end
      chk("s1_ov", ov2, 0);

      // Overflow: bytes after completion, with and without enable.
      rx_valid = 1'b1; rx_data = 8'hAA;
      @(negedge clock);
      rx_valid = 1'b0;
      chk("s4_we0", we2, 0);
      chk("s4_ov0", ov2, 1);
      chk("s4_er0", er2, 1);
      en = 1'b0; rx_valid = 1'b1; rx_data = 8'hBB;
      @(negedge clock);
      rx_valid = 1'b0;
      chk("s4_we1", we2, 0);
      repeat (3) @(negedge clock);
      chk("s4_ov_hold", ov2, 1);
      chk("s4_er_hold", er2, 1);
      chk("s4_bp_hold", bp2, 1);

      // Back-to-back frame.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("s2_ov_clr", ov2, 0);
      en = 1'b1; rx_valid = 1'b1; rx_data = 8'h40;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         chk($sformatf("s2_we[%0d]", i), we2, 1);
         chk($sformatf("s2_addr[%0d]", i), addr2, i);
         chk($sformatf("s2_wdata[%0d]", i), wdata2, 8'h40 + i);
         chk($sformatf("s2_er[%0d]", i), er2, (i == 15) ? 1 : 0);
         if (i < 15) rx_data = rx_data + 8'd1;
         else        rx_valid = 1'b0;
      end
      @(negedge clock);
      chk("s2_we_after", we2, 0);
      chk("s2_ov", ov2, 0);

      // Enable gating: three dropped bytes, then a full frame.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_valid = 1'b1; rx_data = 8'hE0 + 8'(i);
         @(negedge clock);
         rx_valid = 1'b0;
         chk($sformatf("s3_drop_we[%0d]", i), we2, 0);
         chk($sformatf("s3_drop_ov[%0d]", i), ov2, 0);
      end
      en = 1'b1; rx_valid = 1'b1; rx_data = 8'h60;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         chk($sformatf("s3_addr[%0d]", i), addr2, i);
         chk($sformatf("s3_wdata[%0d]", i), wdata2, 8'h60 + i);
         if (i < 15) rx_data = rx_data + 8'd1;
         else        rx_valid = 1'b0;
      end
      @(negedge clock);
      chk("s3_er", er2, 1);
      chk("s3_ov", ov2, 0);

      // Reset mid-frame after 9 bytes.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      rx_valid = 1'b1; rx_data = 8'h80;
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         if (i < 8) rx_data = rx_data + 8'd1;
         else       rx_valid = 1'b0;
      end
      chk("s5_addr8", addr2, 8);
      chk("s5_bp_pre", bp2, 1);
      #2 reset = 1'b1;
      #1;
      chk("s5_rst_we", we2, 0);
      chk("s5_rst_addr", addr2, 0);
      chk("s5_rst_wdata", wdata2, 0);
      chk("s5_rst_rowcol", {row2, col2}, 0);
      chk("s5_rst_flags", {bp2, er2, ov2}, 0);
      @(negedge clock);
      reset = 1'b0;
      rx_valid = 1'b1; rx_data = 8'hC5;
      @(negedge clock);
      rx_valid = 1'b0;
      chk("s5_we", we2, 1);
      chk("s5_addr", addr2, 0);
      chk("s5_rowcol", {row2, col2}, 0);
      chk("s5_wdata", wdata2, 8'hC5);
      rx_valid = 1'b1; rx_data = 8'hC6;
      @(negedge clock);
      rx_valid = 1'b0;
      chk("s5_addr1", addr2, 1);
      chk("s5_col1", col2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rx_frame_writer.md
# rx_frame_writer

Receive-side stage of the downsampling processor. It takes the byte stream from the serial receiver and writes each byte into the frame RAM at consecutive addresses in row-major order. It raises `begin_process` once enough rows are stored for the downsampler to start, and `end_receive` when the whole frame is stored. Both are level flags consumed by the main controller, which sits directly downstream.

## Interface
Parameters:
- `IMG_W`, 256: pixels (bytes) per row, ≥2
- `IMG_H`, 256: rows per frame, ≥2
- `START_ROWS`, 2: complete rows required before `begin_process`, 1..IMG_H
- `ADDR_W`, 16: RAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H

Ports:
- `clock`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `en`  in  1  receive enable from controller (its `s0`); bytes ignored while low
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `rx_data`  in  8  received byte
- `mem_we`  out  1  frame RAM write strobe, one cycle per byte
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  8  write data
- `row`  out  clog2(IMG_H)  row index of the byte being written
- `col`  out  clog2(IMG_W)  column index of the byte being written
- `begin_process`  out  1  sticky; START_ROWS rows stored
- `end_receive`  out  1  sticky; full frame stored
- `overflow`  out  1  sticky; byte arrived after the frame completed

## Operation
- FSM states: IDLE, RECV, DONE. Encoding: IDLE=2'b00, RECV=2'b01, DONE=2'b10.
- **IDLE**
  - Entered on reset.
  - On the first accepted byte (`en && rx_valid`), write it to address 0 and go to RECV.
- **RECV**
  - Every accepted byte is written to the current address. The address then increments by 1.
  - `col` counts 0..IMG_W-1 and wraps to 0; `row` increments on each `col` wrap.
  - After the byte at address IMG_W*IMG_H-1 is written, go to DONE.
- **DONE**
  - No further writes.
  - Any `rx_valid` sets `overflow`, regardless of `en`. The byte is discarded.
  - Exit only via `reset`.
- `rx_valid` while `en`=0 in IDLE or RECV: byte dropped, counters hold, no flag raised.
- `begin_process` sets with the write of address START_ROWS*IMG_W-1.
- `end_receive` sets with the write of address IMG_W*IMG_H-1.
- If START_ROWS=IMG_H, both flags set in the same cycle.
- Once set, `begin_process`, `end_receive` and `overflow` hold until `reset`.
- Address arithmetic:
  - The counter is ADDR_W bits; it never wraps, because completion is detected by compare, not by overflow.
  - The last-byte compare uses the constant IMG_W*IMG_H-1.
- Reset mid-frame:
  - All outputs return to 0 and the state returns to IDLE.
  - Already-written RAM contents are left in place; the next frame overwrites from address 0.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered.
- Byte accepted at edge k → `mem_we`=1, `mem_addr`, `mem_wdata`, `row`, `col` valid after edge k, for exactly one cycle. Latency is 1 clock.
- Back-to-back `rx_valid` on every cycle is supported: one write per cycle, no stall.
- `begin_process` and `end_receive` rise in the same cycle as the `mem_we` of their trigger byte.
- `overflow` rises one cycle after the offending `rx_valid`.
- `mem_addr`, `row`, `col` are don't-care when `mem_we`=0; they hold their last value.

## Structure
- Shared package `ds_pkg`:
  - default `IMG_W`, `IMG_H`, `START_ROWS`
  - receive state encoding
  - `FRAME_BYTES` = IMG_W*IMG_H
- Natural sub-module: `rc_counter`, a row/column counter with enable, column wrap and `last` output. It is reusable by the process and transmit stages.
- The address counter, FSM and sticky flags live in the top level.

## Test plan
Bench parameters: IMG_W=4, IMG_H=4, START_ROWS=2.
1. **Normal frame.** Reset, `en`=1, send bytes 0x10..0x1F, one every 3 cycles.
   - 16 writes: addr 0..15, data 0x10..0x1F, row/col matching row-major order.
   - `begin_process` rises with the addr-7 write; `end_receive` rises with the addr-15 write.
2. **Back-to-back.** Send 16 bytes on consecutive cycles.
   - 16 consecutive `mem_we` cycles, each one cycle after its `rx_valid`.
   - `end_receive` high in the 16th write cycle.
3. **Enable gating.** Send 3 bytes with `en`=0, then 16 bytes with `en`=1.
   - First write is addr 0 with the 4th byte's data.
   - `overflow` stays 0.
4. **Overflow.** After a full frame, send 2 more bytes.
   - No `mem_we`; `overflow`=1 and held; `end_receive` stays 1.
5. **Reset mid-frame.** Assert `reset` asynchronously after 9 bytes.
   - All outputs 0 immediately, including `begin_process`.
   - The next byte is written to addr 0, row 0, col 0.
6. **START_ROWS=IMG_H.** Rerun scenario 1 with START_ROWS=4.
   - `begin_process` and `end_receive` rise together with the addr-15 write.
